// File: rtl/pacman_pkg.sv
// Purpose: shared maze geometry, coordinate/row types and tracker state encoding.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: COLS/ROWS/PELLET_PTS, coord_t, row_t, tracker_state_t, popcount().
package pacman_pkg;

    localparam int COLS       = 21;   // maze columns per row
    localparam int ROWS       = 22;   // maze rows
    localparam int PELLET_PTS = 10;   // score per pellet eaten
    localparam int COORD_W    = 5;    // cell coordinate width
    localparam int LEFT_W     = 9;    // pellets_left counter width
    localparam int POP_W      = $clog2(COLS + 1);

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COLS-1:0]    row_t;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        IDLE  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } tracker_state_t;

    // Coordinate-width bounds so range checks compare like with like.
    localparam coord_t COLS_C   = coord_t'(COLS);
    localparam coord_t ROWS_C   = coord_t'(ROWS);
    localparam coord_t LAST_ROW = coord_t'(ROWS - 1);

    // Number of pellets in one row.
    function automatic logic [POP_W-1:0] popcount(input row_t r);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < COLS; i++) begin
            c = c + {{(POP_W-1){1'b0}}, r[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pellet_layout_rom.sv
// Purpose: level pellet layout, one COLS-bit row per maze row (bit i = column i).
// Latency: combinational.
// Backpressure: none.
// Ports: row_idx (row address), row_bits (pellet bits of that row; 0 beyond ROWS-1).
// Pellets sit only on corridor cells, never on a wall cell of the maze map; the
// tracker never checks walls itself because of that.
module pellet_layout_rom
    import pacman_pkg::*;
(
    input  coord_t row_idx,
    output row_t   row_bits
);

    always_comb begin
        row_bits = '0;
        case (row_idx)
            5'd1:    row_bits = 21'h0FFBFE;
            5'd2:    row_bits = 21'h042422;
            5'd3:    row_bits = 21'h0FFFFE;
            5'd4:    row_bits = 21'h042422;
            5'd5:    row_bits = 21'h0FBDFE;
            5'd6:    row_bits = 21'h040402;
            5'd7:    row_bits = 21'h040402;
            5'd8:    row_bits = 21'h040402;
            5'd9:    row_bits = 21'h040402;
            5'd10:   row_bits = 21'h0FC07E;
            5'd11:   row_bits = 21'h040402;
            5'd12:   row_bits = 21'h0FFFFE;
            5'd13:   row_bits = 21'h040402;
            5'd14:   row_bits = 21'h040402;
            5'd15:   row_bits = 21'h0FFBFE;
            5'd16:   row_bits = 21'h021482;
            5'd17:   row_bits = 21'h0FFFFE;
            5'd18:   row_bits = 21'h044444;
            5'd19:   row_bits = 21'h0FFFFE;
            5'd20:   row_bits = 21'h0FFFFE;
            default: row_bits = '0;
        endcase
    end

endmodule

// File: rtl/pellet_tracker.sv
// Purpose: writable pellet map; loads the layout, clears pellets Pac-Man walks onto, keeps score/count.
// Latency: move_stb at T -> eat at T+2, score/pellets_left visible at T+3; rd_row 1 cycle after rd_y.
// Backpressure: none; move_stb outside IDLE is dropped (move ticks are far slower than clk).
// Ports: clk, reset (sync, active-high), move_stb/curr_x/curr_y (move tick + cell), restart (reload level),
//        rd_y/rd_row (renderer row port), eat, score, pellets_left, level_clear, busy.
module pellet_tracker
    import pacman_pkg::*;
#(
    parameter int SCORE_W = 16
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               move_stb,
    input  coord_t             curr_x,
    input  coord_t             curr_y,
    input  logic               restart,
    input  coord_t             rd_y,
    output row_t               rd_row,
    output logic               eat,
    output logic [SCORE_W-1:0] score,
    output logic [LEFT_W-1:0]  pellets_left,
    output logic               level_clear,
    output logic               busy
);

    localparam row_t              ROW_ONE  = row_t'(1);
    localparam logic [LEFT_W-1:0] LEFT_ONE = LEFT_W'(1);

    tracker_state_t state, state_nxt;

    row_t   mem [ROWS];
    row_t   rom_row;
    row_t   row_q;
    coord_t cnt;
    coord_t x_q;
    coord_t y_q;

    logic   abort;
    logic   hit;
    logic   load_step;
    logic   latch;
    logic   fetch;
    logic   eat_c;
    logic   mem_we;
    coord_t mem_wa;
    row_t   mem_wd;

    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

    pellet_layout_rom u_rom (
        .row_idx  (cnt),
        .row_bits (rom_row)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_step = 1'b0;
        latch     = 1'b0;
        fetch     = 1'b0;
        eat_c     = 1'b0;
        abort     = reset | restart;
        hit       = row_q[x_q];

        case (state)
            LOAD: begin
                load_step = 1'b1;
                if (cnt == LAST_ROW) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (move_stb && (curr_x < COLS_C) && (curr_y < ROWS_C)) begin
                    latch     = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                fetch     = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                eat_c     = hit;
                // Eating the last pellet ends the level.
                state_nxt = (hit && (pellets_left == LEFT_ONE)) ? DONE : IDLE;
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase

        // Reset or restart abandons any in-flight update: no eat, no write.
        if (abort) begin
            state_nxt = LOAD;
            load_step = 1'b0;
            latch     = 1'b0;
            fetch     = 1'b0;
            eat_c     = 1'b0;
        end
    end

    // ---------------- pellet array ----------------
    always_comb begin
        mem_we = load_step | eat_c;
        mem_wa = load_step ? cnt : y_q;
        mem_wd = load_step ? rom_row : (row_q & ~(ROW_ONE << x_q));
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Renderer port: plain registered read, so a same-edge write shows up one read later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_row <= '0;
        end else begin
            rd_row <= (rd_y < ROWS_C) ? mem[rd_y] : '0;
        end
    end

    // ---------------- datapath ----------------
    always_comb begin
        score_sum = {1'b0, score} + (SCORE_W+1)'(PELLET_PTS);
        score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            row_q        <= '0;
            pellets_left <= '0;
            score        <= '0;
        end else if (restart) begin
            // Score carries over into the next level.
            cnt          <= '0;
            pellets_left <= '0;
        end else begin
            if (load_step) begin
                cnt          <= cnt + 1'b1;
                pellets_left <= pellets_left + LEFT_W'(popcount(rom_row));
            end
            if (latch) begin
                x_q <= curr_x;
                y_q <= curr_y;
            end
            if (fetch) begin
                row_q <= mem[y_q];
            end
            if (eat_c) begin
                pellets_left <= pellets_left - LEFT_ONE;
                score        <= score_sat;
            end
        end
    end

    assign eat         = eat_c;
    assign busy        = (state == LOAD);
    assign level_clear = (state == DONE);

endmodule

// File: tb/tb_pellet_tracker.sv
// Purpose: randomized + scripted bench for pellet_tracker with a queue scoreboard and cell-map model.
// Latency: checks eat at strobe+2 and score/pellets_left the cycle after each eat.
// Backpressure: n/a; strobes are spaced so the tracker is always back in IDLE/DONE.
module tb_pellet_tracker;

    localparam int COLS  = 21;
    localparam int ROWS  = 22;
    localparam int PTS   = 10;
    localparam int SMAX  = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic        move_stb;
    logic [4:0]  curr_x;
    logic [4:0]  curr_y;
    logic        restart;
    logic [4:0]  rd_y;
    logic [20:0] rd_row;
    logic        eat;
    logic [15:0] score;
    logic [8:0]  pellets_left;
    logic        level_clear;
    logic        busy;

    always #5 clk = ~clk;

    pellet_tracker #(.SCORE_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .move_stb     (move_stb),
        .curr_x       (curr_x),
        .curr_y       (curr_y),
        .restart      (restart),
        .rd_y         (rd_y),
        .rd_row       (rd_row),
        .eat          (eat),
        .score        (score),
        .pellets_left (pellets_left),
        .level_clear  (level_clear),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the level layout, the live pellet map and counters.
    logic [20:0] layout [ROWS];
    logic [20:0] pmap   [ROWS];
    int m_total;
    int m_left;
    int m_score;
    bit m_done;
    bit m_loading;

    typedef struct {
        int score;
        int left;
    } exp_t;
    exp_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reload();
        for (int y = 0; y < ROWS; y++) pmap[y] = layout[y];
        m_left = m_total;
        m_done = 1'b0;
    endtask

    function automatic bit find_pellet(output int fx, output int fy);
        fx = 0;
        fy = 0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                if (pmap[y][x]) begin
                    fx = x;
                    fy = y;
                    return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    // Wait for busy to drop; n = cycles spent busy after the reset/restart edge.
    task automatic wait_load(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic do_restart(output int n);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        model_reload();
        wait_load(n);
    endtask

    // One move tick at (x,y). abort_reset asserts reset during the WRITE cycle.
    task automatic strobe(input int x, input int y, input bit abort_reset = 1'b0);
        bit   hit;
        exp_t e;
        hit = 1'b0;
        if (!m_loading && !m_done && !abort_reset && x < COLS && y < ROWS) begin
            hit = pmap[y][x];
        end
        if (hit) begin
            pmap[y][x] = 1'b0;
            m_left--;
            m_score = (m_score + PTS > SMAX) ? SMAX : m_score + PTS;
            e.score = m_score;
            e.left  = m_left;
            sb.push_back(e);
            if (m_left == 0) m_done = 1'b1;
        end
        curr_x   = 5'(x);
        curr_y   = 5'(y);
        move_stb = 1'b1;
        tick();
        move_stb = 1'b0;
        @(negedge clk);
        check("eat_early", {31'd0, eat}, 32'd0);
        tick();
        if (abort_reset) reset = 1'b1;
        @(negedge clk);
        check("eat_latency", {31'd0, eat}, {31'd0, hit});
        tick();
    endtask

    task automatic check_rows(input string name);
        for (int y = 0; y < ROWS; y++) begin
            rd_y = 5'(y);
            tick();
            check(name, {11'd0, rd_row}, {11'd0, pmap[y]});
        end
    endtask

    task automatic check_reset_out();
        check("rst_score", {16'd0, score}, 32'd0);
        check("rst_left",  {23'd0, pellets_left}, 32'd0);
        check("rst_eat",   {31'd0, eat}, 32'd0);
        check("rst_clear", {31'd0, level_clear}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd1);
        check("rst_rdrow", {11'd0, rd_row}, 32'd0);
    endtask

    // Scoreboard monitor: every eat pulse must match a queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (eat === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_eat: eat=1 with no pellet expected (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    @(negedge clk);
                    check("sb_score", {16'd0, score}, e.score);
                    check("sb_left",  {23'd0, pellets_left}, e.left);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int fx;
        int fy;
        int sx;
        int sy;

        layout[0]  = 21'h000000; layout[1]  = 21'h0FFBFE; layout[2]  = 21'h042422;
        layout[3]  = 21'h0FFFFE; layout[4]  = 21'h042422; layout[5]  = 21'h0FBDFE;
        layout[6]  = 21'h040402; layout[7]  = 21'h040402; layout[8]  = 21'h040402;
        layout[9]  = 21'h040402; layout[10] = 21'h0FC07E; layout[11] = 21'h040402;
        layout[12] = 21'h0FFFFE; layout[13] = 21'h040402; layout[14] = 21'h040402;
        layout[15] = 21'h0FFBFE; layout[16] = 21'h021482; layout[17] = 21'h0FFFFE;
        layout[18] = 21'h044444; layout[19] = 21'h0FFFFE; layout[20] = 21'h0FFFFE;
        layout[21] = 21'h000000;
        m_total = 0;
        for (int y = 0; y < ROWS; y++) m_total += $countones(layout[y]);
        m_score   = 0;
        m_loading = 1'b0;
        model_reload();

        reset    = 1'b1;
        move_stb = 1'b0;
        restart  = 1'b0;
        curr_x   = '0;
        curr_y   = '0;
        rd_y     = 5'd12;

        // 1: reset and layout load
        tick();
        tick();
        check_reset_out();
        reset = 1'b0;
        wait_load(n);
        check("load_cycles", n, ROWS);
        check("load_left",   {23'd0, pellets_left}, m_total);
        check("load_score",  {16'd0, score}, 32'd0);
        check("load_clear",  {31'd0, level_clear}, 32'd0);
        check_rows("load_row");
        rd_y = 5'd25;
        tick();
        check("rd_oob", {11'd0, rd_row}, 32'd0);

        // 2: eat (10,12); renderer sees old row on the write edge, new row after
        rd_y = 5'd12;
        strobe(10, 12);
        check("rd_old_bit", {31'd0, rd_row[10]}, 32'd1);
        tick();
        check("rd_new_bit", {31'd0, rd_row[10]}, 32'd0);
        check("eat1_score", {16'd0, score}, 32'd10);
        check("eat1_left",  {23'd0, pellets_left}, m_total - 1);

        // 3: same cell again
        strobe(10, 12);
        check("rep_score", {16'd0, score}, 32'd10);
        check("rep_left",  {23'd0, pellets_left}, m_total - 1);

        // 4: out-of-range cells, then a strobe during LOAD
        strobe(25, 3);
        strobe(3, 30);
        check("oob_left", {23'd0, pellets_left}, m_left);
        check("oob_busy", {31'd0, busy}, 32'd0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        model_reload();
        m_loading = 1'b1;
        strobe(10, 12);
        m_loading = 1'b0;
        wait_load(n);
        check("ld_busy_done", {31'd0, busy}, 32'd0);
        check("ld_left",      {23'd0, pellets_left}, m_total);
        check("ld_score",     {16'd0, score}, 32'd10);

        // random strobes, including out-of-range cells
        for (int i = 0; i < 60; i++) begin
            strobe($urandom_range(0, 26), $urandom_range(0, 24));
        end
        check("rand_left", {23'd0, pellets_left}, m_left);

        // 5: clear the level, ignore strobes in DONE, restart
        while (find_pellet(fx, fy)) strobe(fx, fy);
        check("done_left",  {23'd0, pellets_left}, 32'd0);
        check("done_clear", {31'd0, level_clear}, 32'd1);
        strobe(10, 12);
        strobe(1, 1);
        check("done_hold", {31'd0, level_clear}, 32'd1);
        do_restart(n);
        check("rs_cycles", n, ROWS);
        check("rs_left",   {23'd0, pellets_left}, m_total);
        check("rs_score",  {16'd0, score}, m_score);
        check("rs_clear",  {31'd0, level_clear}, 32'd0);
        check_rows("rs_row");

        // 6: play levels until score is 0xFFFA, then saturate
        while (m_score < 65530) begin
            if (m_done) begin
                do_restart(n);
            end else begin
                sx = 0;
                sy = 0;
                void'(find_pellet(sx, sy));
                strobe(sx, sy);
            end
        end
        check("pre_sat", {16'd0, score}, 32'hFFFA);
        for (int k = 0; k < 2; k++) begin
            if (m_done) do_restart(n);
            void'(find_pellet(sx, sy));
            strobe(sx, sy);
            check("sat_score", {16'd0, score}, 32'hFFFF);
        end

        // reset during WRITE
        if (m_done) do_restart(n);
        void'(find_pellet(sx, sy));
        rd_y = 5'(sy);
        strobe(sx, sy, 1'b1);
        check_reset_out();
        reset   = 1'b0;
        m_score = 0;
        model_reload();
        wait_load(n);
        check("post_rst_cycles", n, ROWS);
        check("post_rst_left",   {23'd0, pellets_left}, m_total);

        tick();
        tick();
        check("sb_drain", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
